// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: two-channel round-robin arbiter sequencing accesses to one async SRAM with wait states and a recovery cycle.
// Define SRAM_ARB_FIXED_PRIO_EN to give ch0 strict priority instead of round-robin.
module sram_rr_arbiter #(
  parameter int aw          = 19,
  parameter int dw          = 8,
  parameter int wait_states = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ch0_req,
  input  logic          ch0_we,
  input  logic [aw-1:0] ch0_addr,
  input  logic [dw-1:0] ch0_wdata,
  output logic          ch0_ack,
  output logic [dw-1:0] ch0_rdata,
  output logic          ch0_rvalid,
  input  logic          ch1_req,
  input  logic          ch1_we,
  input  logic [aw-1:0] ch1_addr,
  input  logic [dw-1:0] ch1_wdata,
  output logic          ch1_ack,
  output logic [dw-1:0] ch1_rdata,
  output logic          ch1_rvalid,
  output logic [aw-1:0] sram_addr,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [dw-1:0] sram_dat_wr,
  output logic          sram_dat_oe,
  input  logic [dw-1:0] sram_dat_rd
);
  localparam int CW = wait_states > 0 ? $clog2(wait_states + 1) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          gnt_q, we_q, ce_n_q, oe_n_q, we_n_q, dat_oe_q;
  logic [1:0]    ack_q, rvalid_q;
  logic [dw-1:0] rdata0_q, rdata1_q, dat_wr_q;
  logic [aw-1:0] addr_q;
  logic          win, sel_we;
`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb win = ~ch0_req;
`else
  logic last_q;
  always_comb win = (ch0_req & ch1_req) ? ~last_q : ch1_req;
  always_ff @(posedge clk)
    if (rst) last_q <= 1'b1;
    else if (state_q == IDLE && en && (ch0_req | ch1_req)) last_q <= win;
`endif
  always_comb sel_we = win ? ch1_we : ch0_we;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      ack_q    <= '0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      addr_q   <= '0;
      dat_wr_q <= '0;
      dat_oe_q <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
    end else begin
      ack_q    <= '0;
      rvalid_q <= '0;
      case (state_q)
        IDLE: if (en && (ch0_req | ch1_req)) begin
          state_q  <= ACCESS;
          cnt_q    <= CW'(wait_states);
          gnt_q    <= win;
          we_q     <= sel_we;
          ack_q    <= win ? 2'b10 : 2'b01;
          addr_q   <= win ? ch1_addr : ch0_addr;
          dat_wr_q <= win ? ch1_wdata : ch0_wdata;
          dat_oe_q <= sel_we;
          ce_n_q   <= 1'b0;
          oe_n_q   <= sel_we;
          we_n_q   <= ~sel_we;
        end
        ACCESS: if (cnt_q == '0) begin
          state_q <= HOLD;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          if (!we_q) begin
            rvalid_q[gnt_q] <= 1'b1;
            if (gnt_q) rdata1_q <= sram_dat_rd;
            else rdata0_q <= sram_dat_rd;
          end
        end else cnt_q <= cnt_q - 1'b1;
        HOLD: begin
          state_q  <= IDLE;
          ce_n_q   <= 1'b1;
          dat_oe_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ch0_ack     = ack_q[0];
  assign ch1_ack     = ack_q[1];
  assign ch0_rvalid  = rvalid_q[0];
  assign ch1_rvalid  = rvalid_q[1];
  assign ch0_rdata   = rdata0_q;
  assign ch1_rdata   = rdata1_q;
  assign sram_addr   = addr_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_dat_wr = dat_wr_q;
  assign sram_dat_oe = dat_oe_q;
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter: directed checks of sram_rr_arbiter with wait_states=1 (main) and wait_states=0 (throughput).
module tb_sram_rr_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, en;
  logic        ch0_req, ch0_we, ch1_req, ch1_we;
  logic [18:0] ch0_addr, ch1_addr;
  logic [7:0]  ch0_wdata, ch1_wdata, sram_dat_rd;
  logic        ch0_ack, ch1_ack, ch0_rvalid, ch1_rvalid;
  logic [7:0]  ch0_rdata, ch1_rdata, sram_dat_wr;
  logic [18:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dat_oe;
  logic        b_req0, b_req1;
  logic        b_ack0, b_ack1, b_rv0, b_rv1, b_ce_n, b_oe_n, b_we_n, b_dat_oe;
  logic [7:0]  b_rd0, b_rd1, b_wr;
  logic [18:0] b_addr;
  int checks = 0, errors = 0;

  sram_rr_arbiter #(.aw(19), .dw(8), .wait_states(1)) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .ch0_req(ch0_req), .ch0_we(ch0_we), .ch0_addr(ch0_addr), .ch0_wdata(ch0_wdata),
    .ch0_ack(ch0_ack), .ch0_rdata(ch0_rdata), .ch0_rvalid(ch0_rvalid),
    .ch1_req(ch1_req), .ch1_we(ch1_we), .ch1_addr(ch1_addr), .ch1_wdata(ch1_wdata),
    .ch1_ack(ch1_ack), .ch1_rdata(ch1_rdata), .ch1_rvalid(ch1_rvalid),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_dat_wr(sram_dat_wr), .sram_dat_oe(sram_dat_oe),
    .sram_dat_rd(sram_dat_rd)
  );

  sram_rr_arbiter #(.aw(19), .dw(8), .wait_states(0)) u_ws0 (
    .clk(clk), .rst(rst), .en(en),
    .ch0_req(b_req0), .ch0_we(1'b0), .ch0_addr(19'h00001), .ch0_wdata(8'h00),
    .ch0_ack(b_ack0), .ch0_rdata(b_rd0), .ch0_rvalid(b_rv0),
    .ch1_req(b_req1), .ch1_we(1'b0), .ch1_addr(19'h00002), .ch1_wdata(8'h00),
    .ch1_ack(b_ack1), .ch1_rdata(b_rd1), .ch1_rvalid(b_rv1),
    .sram_addr(b_addr), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n),
    .sram_we_n(b_we_n), .sram_dat_wr(b_wr), .sram_dat_oe(b_dat_oe),
    .sram_dat_rd(8'h77)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1; en = 1; ch0_req = 0; ch0_we = 0; ch0_addr = '0; ch0_wdata = '0;
    ch1_req = 0; ch1_we = 0; ch1_addr = '0; ch1_wdata = '0; sram_dat_rd = 8'h00;
    b_req0 = 0; b_req1 = 0;
    tick; tick;
    chk("rst_ce_n", 32'(sram_ce_n), 1);
    chk("rst_oe_n", 32'(sram_oe_n), 1);
    chk("rst_we_n", 32'(sram_we_n), 1);
    chk("rst_dat_oe", 32'(sram_dat_oe), 0);
    chk("rst_acks", {ch1_ack, ch0_ack, ch1_rvalid, ch0_rvalid}, 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_rdata", {ch1_rdata, ch0_rdata, sram_dat_wr}, 0);
    rst = 0;
    // test 1: ch0 read
    ch0_req = 1; ch0_we = 0; ch0_addr = 19'h12345;
    tick;
    chk("t1_ack0", 32'(ch0_ack), 1);
    chk("t1_ack1", 32'(ch1_ack), 0);
    chk("t1_oe_n_c1", 32'(sram_oe_n), 0);
    chk("t1_ce_n_c1", 32'(sram_ce_n), 0);
    chk("t1_we_n_c1", 32'(sram_we_n), 1);
    chk("t1_dat_oe", 32'(sram_dat_oe), 0);
    chk("t1_addr", 32'(sram_addr), 32'h12345);
    ch0_req = 0; ch0_addr = 19'h0;
    tick;
    chk("t1_ack0_c2", 32'(ch0_ack), 0);
    chk("t1_oe_n_c2", 32'(sram_oe_n), 0);
    chk("t1_rvalid_c2", 32'(ch0_rvalid), 0);
    sram_dat_rd = 8'hA5;
    tick;
    sram_dat_rd = 8'h00;
    chk("t1_rvalid0", 32'(ch0_rvalid), 1);
    chk("t1_rdata0", 32'(ch0_rdata), 32'hA5);
    chk("t1_ch1_quiet", {ch1_ack, ch1_rvalid}, 0);
    chk("t1_oe_n_c3", 32'(sram_oe_n), 1);
    chk("t1_ce_n_c3", 32'(sram_ce_n), 0);
    chk("t1_addr_hold", 32'(sram_addr), 32'h12345);
    tick;
    chk("t1_ce_n_c4", 32'(sram_ce_n), 1);
    chk("t1_rvalid_c4", 32'(ch0_rvalid), 0);
    // test 2: ch1 write
    ch1_req = 1; ch1_we = 1; ch1_addr = 19'h00010; ch1_wdata = 8'h3C;
    tick;
    chk("t2_ack1", 32'(ch1_ack), 1);
    chk("t2_ack0", 32'(ch0_ack), 0);
    chk("t2_we_n_c1", 32'(sram_we_n), 0);
    chk("t2_oe_n_c1", 32'(sram_oe_n), 1);
    chk("t2_dat_c1", {sram_dat_oe, sram_dat_wr}, 32'h13C);
    chk("t2_addr", 32'(sram_addr), 32'h10);
    ch1_req = 0; ch1_wdata = 8'h00;
    tick;
    chk("t2_we_n_c2", 32'(sram_we_n), 0);
    chk("t2_dat_c2", {sram_dat_oe, sram_dat_wr}, 32'h13C);
    tick;
    chk("t2_we_n_c3", 32'(sram_we_n), 1);
    chk("t2_dat_c3", {sram_dat_oe, sram_dat_wr}, 32'h13C);
    chk("t2_ce_n_c3", 32'(sram_ce_n), 0);
    chk("t2_no_rvalid", {ch1_rvalid, ch0_rvalid}, 0);
    tick;
    chk("t2_dat_oe_c4", 32'(sram_dat_oe), 0);
    chk("t2_ce_n_c4", 32'(sram_ce_n), 1);
    // test 3: both requesting continuously, ws=1 -> grant every 4 cycles
    ch0_req = 1; ch1_req = 1; ch0_we = 0; ch1_we = 0;
    for (int g = 0; g < 4; g++) begin
      tick;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      chk($sformatf("t3_ack_g%0d", g), {ch1_ack, ch0_ack}, 32'b01);
`else
      chk($sformatf("t3_ack_g%0d", g), {ch1_ack, ch0_ack}, (g % 2 == 0) ? 32'b01 : 32'b10);
`endif
      for (int k = 0; k < 3; k++) begin
        tick;
        chk($sformatf("t3_gap_g%0d_%0d", g, k), {ch1_ack, ch0_ack}, 0);
      end
    end
    ch0_req = 0; ch1_req = 0;
    tick;
    chk("t3_idle", 32'(sram_ce_n), 1);
    // test 3b: ws=0 instance -> grant every 3 cycles
    b_req0 = 1; b_req1 = 1;
    for (int g = 0; g < 4; g++) begin
      tick;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      chk($sformatf("t3b_ack_g%0d", g), {b_ack1, b_ack0}, 32'b01);
`else
      chk($sformatf("t3b_ack_g%0d", g), {b_ack1, b_ack0}, (g % 2 == 0) ? 32'b01 : 32'b10);
`endif
      for (int k = 0; k < 2; k++) begin
        tick;
        chk($sformatf("t3b_gap_g%0d_%0d", g, k), {b_ack1, b_ack0}, 0);
      end
    end
    b_req0 = 0; b_req1 = 0;
    // test 4: en low blocks grants
    en = 0; ch0_req = 1;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk($sformatf("t4_blocked_%0d", k), {sram_ce_n, ch1_ack, ch0_ack}, 32'b100);
    end
    en = 1;
    tick;
    chk("t4_ack0", 32'(ch0_ack), 1);
    ch0_req = 0;
    tick; tick; tick;
    chk("t4_idle", 32'(sram_ce_n), 1);
    // test 5: reset during second ACCESS cycle of a write
    ch0_req = 1; ch0_we = 1; ch0_addr = 19'h00ABC; ch0_wdata = 8'h5A;
    tick;
    chk("t5_ack0", 32'(ch0_ack), 1);
    ch0_req = 0;
    tick;
    chk("t5_we_n_c2", 32'(sram_we_n), 0);
    rst = 1;
    tick;
    rst = 0;
    chk("t5_we_n", 32'(sram_we_n), 1);
    chk("t5_ce_n", 32'(sram_ce_n), 1);
    chk("t5_dat_oe", 32'(sram_dat_oe), 0);
    chk("t5_addr", 32'(sram_addr), 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("t5_quiet_%0d", k), {sram_ce_n, ch1_ack, ch0_ack, ch1_rvalid, ch0_rvalid}, 32'b10000);
    end
    // after reset a tie goes to ch0
    ch0_req = 1; ch1_req = 1; ch0_we = 0; ch1_we = 0;
    tick;
    chk("t6_first_tie", {ch1_ack, ch0_ack}, 32'b01);
    ch0_req = 0; ch1_req = 0;
    tick; tick; tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
